// File: rtl/conv_seq_ctrl.sv
// Convolution address sequencer: walks k and the valid j range, driving X/Y reads, the MAC and Z writes.
// Optional abort input and aborted flag are enabled with `define CONV_ABORT_EN.
module conv_seq_ctrl #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   size_x,
    input  logic [ADDR_W:0]   size_y,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_x,
    output logic [ADDR_W-1:0] addr_y,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              z_we,
    output logic [ADDR_W:0]   addr_z,
    output logic              busy,
    output logic              done,
`ifdef CONV_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              err
);

    localparam int unsigned KW       = ADDR_W + 1;
    localparam int unsigned SW       = ADDR_W + 2;
    localparam int unsigned MAX_SIZE = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_DRAIN,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     sx_q, sx_d, sy_q, sy_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] j_q, j_d, jhi_q, jhi_d;
    logic              err_q, err_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d;
    logic              mac_clr_q, mac_clr_d;
    logic              mac_en_q, mac_en_d;
    logic              z_we_q, z_we_d;
    logic [KW-1:0]     addr_z_q, addr_z_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef CONV_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    logic [KW-1:0]     sx_m1_c, sy_m1_c, jlo_c, jhi_c;
    logic              k_last_c, size_bad_c;

    // Inner-loop bounds for the current k and the final-k / illegal-size tests
    always_comb begin
        sx_m1_c    = sx_q - KW'(1);
        sy_m1_c    = sy_q - KW'(1);
        jlo_c      = (k_q > sy_m1_c) ? (k_q - sy_m1_c) : '0;
        jhi_c      = (k_q < sx_m1_c) ? k_q : sx_m1_c;
        k_last_c   = (SW'(k_q) == (SW'(sx_q) + SW'(sy_q) - SW'(2)));
        size_bad_c = (size_x == '0) || (size_y == '0) ||
                     (size_x > KW'(MAX_SIZE)) || (size_y > KW'(MAX_SIZE));
    end

    always_comb begin
        state_d   = state_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        k_d       = k_q;
        j_d       = j_q;
        jhi_d     = jhi_q;
        err_d     = err_q;
        mac_en_d  = rd_en_q;
`ifdef CONV_ABORT_EN
        aborted_d = aborted_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sx_d = size_x;
                    sy_d = size_y;
`ifdef CONV_ABORT_EN
                    aborted_d = 1'b0;
`endif
                    if (size_bad_c) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        k_d     = '0;
                        state_d = S_CLR;
                    end
                end
            end
            S_CLR: begin
                j_d     = ADDR_W'(jlo_c);
                jhi_d   = ADDR_W'(jhi_c);
                state_d = S_RD;
            end
            S_RD: begin
                if (j_q == jhi_q) begin
                    state_d = S_DRAIN;
                end else begin
                    j_d = j_q + ADDR_W'(1);
                end
            end
            S_DRAIN: state_d = S_WR;
            S_WR: begin
                if (k_last_c) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_CLR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef CONV_ABORT_EN
        // Abort wins over normal sequencing and drops the in-flight product
        if (abort && (state_q inside {S_CLR, S_RD, S_DRAIN, S_WR})) begin
            state_d   = S_DONE;
            mac_en_d  = 1'b0;
            aborted_d = 1'b1;
        end
`endif

        // Outputs decoded from the next state so they are registered alongside it
        rd_en_d   = (state_d == S_RD);
        addr_x_d  = (state_d == S_RD) ? j_d : '0;
        addr_y_d  = (state_d == S_RD) ? ADDR_W'(k_d - KW'(j_d)) : '0;
        mac_clr_d = (state_d == S_CLR);
        z_we_d    = (state_d == S_WR);
        addr_z_d  = (state_d == S_WR) ? k_d : '0;
        busy_d    = (state_d inside {S_CLR, S_RD, S_DRAIN, S_WR});
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sx_q      <= '0;
            sy_q      <= '0;
            k_q       <= '0;
            j_q       <= '0;
            jhi_q     <= '0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_x_q  <= '0;
            addr_y_q  <= '0;
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            z_we_q    <= 1'b0;
            addr_z_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CONV_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            k_q       <= k_d;
            j_q       <= j_d;
            jhi_q     <= jhi_d;
            err_q     <= err_d;
            rd_en_q   <= rd_en_d;
            addr_x_q  <= addr_x_d;
            addr_y_q  <= addr_y_d;
            mac_clr_q <= mac_clr_d;
            mac_en_q  <= mac_en_d;
            z_we_q    <= z_we_d;
            addr_z_q  <= addr_z_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef CONV_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign rd_en   = rd_en_q;
    assign addr_x  = addr_x_q;
    assign addr_y  = addr_y_q;
    assign mac_clr = mac_clr_q;
    assign mac_en  = mac_en_q;
    assign z_we    = z_we_q;
    assign addr_z  = addr_z_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
`ifdef CONV_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized self-checking bench for conv_seq_ctrl against a per-cycle expected-output queue
// built from the convolution index rules.
module tb_conv_seq_ctrl;

    localparam int unsigned ADDR_W = 5;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [4:0] ax;
        logic [4:0] ay;
        logic       clr;
        logic       men;
        logic       zwe;
        logic [5:0] az;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   size_x = '0;
    logic [ADDR_W:0]   size_y = '0;
    logic              rd_en, mac_clr, mac_en, z_we, busy, done, err;
    logic [ADDR_W-1:0] addr_x, addr_y;
    logic [ADDR_W:0]   addr_z;
`ifdef CONV_ABORT_EN
    logic              abort = 1'b0;
    logic              aborted;
`endif

    conv_seq_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .size_x  (size_x),
        .size_y  (size_y),
        .rd_en   (rd_en),
        .addr_x  (addr_x),
        .addr_y  (addr_y),
        .mac_clr (mac_clr),
        .mac_en  (mac_en),
        .z_we    (z_we),
        .addr_z  (addr_z),
        .busy    (busy),
        .done    (done),
`ifdef CONV_ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .err     (err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    rec_t expq[$];
    logic exp_err = 1'b0;
    int   busy_cnt, zwe_cnt, last_az;

    function automatic rec_t get_act();
        rec_t a;
        a.busy = busy; a.done = done; a.rd_en = rd_en;
        a.ax = addr_x; a.ay = addr_y;
        a.clr = mac_clr; a.men = mac_en; a.zwe = z_we; a.az = addr_z;
        return a;
    endfunction

    // Addresses only carry meaning while their strobe is high
    function automatic rec_t mask(input rec_t r);
        rec_t m = r;
        if (!m.rd_en) begin m.ax = '0; m.ay = '0; end
        if (!m.zwe) m.az = '0;
        return m;
    endfunction

    task automatic expect_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_now();
        rec_t e, a;
        e = '0;
        if (expq.size() > 0) e = expq.pop_front();
        a = get_act();
        checks++;
        if (mask(a) !== mask(e)) begin
            errors++;
            $display("FAIL outputs t=%0t got %h expected %h", $time, a, e);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err t=%0t got %b expected %b", $time, err, exp_err);
        end
        busy_cnt += int'(a.busy);
        zwe_cnt  += int'(a.zwe);
        if (a.zwe) last_az = int'(a.az);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_now();
    endtask

    // Expected per-cycle outputs: for each k a clear, one read per term, drain, write; then done
    task automatic build_run(input int sx, input int sy);
        rec_t r;
        expq.delete();
        if (sx < 1 || sx > 32 || sy < 1 || sy > 32) begin
            r = '0; r.done = 1'b1; expq.push_back(r);
            return;
        end
        for (int k = 0; k <= sx + sy - 2; k++) begin
            int lo, hi;
            lo = (k - (sy - 1) > 0) ? k - (sy - 1) : 0;
            hi = (k < sx - 1) ? k : sx - 1;
            r = '0; r.busy = 1'b1; r.clr = 1'b1; expq.push_back(r);
            for (int j = lo; j <= hi; j++) begin
                r = '0; r.busy = 1'b1; r.rd_en = 1'b1;
                r.ax = 5'(j); r.ay = 5'(k - j); r.men = (j != lo);
                expq.push_back(r);
            end
            r = '0; r.busy = 1'b1; r.men = 1'b1; expq.push_back(r);
            r = '0; r.busy = 1'b1; r.zwe = 1'b1; r.az = 6'(k); expq.push_back(r);
        end
        r = '0; r.done = 1'b1; expq.push_back(r);
    endtask

    task automatic launch(input int sx, input int sy);
        size_x = 6'(sx);
        size_y = 6'(sy);
        build_run(sx, sy);
        exp_err  = (sx < 1 || sx > 32 || sy < 1 || sy > 32);
        busy_cnt = 0; zwe_cnt = 0; last_az = -1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run(input int sx, input int sy, input bit noise);
        int n = 0;
        launch(sx, sy);
        while (expq.size() > 0 && n < 5000) begin
            if (noise) begin
                start  = ($urandom % 3 == 0);
                size_x = 6'($urandom);
                size_y = 6'($urandom);
            end
            step();
            n++;
        end
        start = 1'b0;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL run_timeout left=%0d", expq.size());
            expq.delete();
        end
        // start while DONE is showing must be dropped
        if (noise && ($urandom % 2 == 0)) start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_now();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Async reset in the middle of a read burst
        launch(3, 3);
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (get_act() !== rec_t'(0) || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_rd got %h err=%b expected 0", get_act(), err);
        end
        expq.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        run(3, 3, 1'b0);
        expect_int("busy_3x3", busy_cnt, 24);
        expect_int("writes_3x3", zwe_cnt, 5);
        expect_int("last_az_3x3", last_az, 4);

        run(1, 1, 1'b0);
        expect_int("busy_1x1", busy_cnt, 4);
        expect_int("writes_1x1", zwe_cnt, 1);

        run(32, 32, 1'b0);
        expect_int("busy_32x32", busy_cnt, 1213);
        expect_int("writes_32x32", zwe_cnt, 63);
        expect_int("last_az_32x32", last_az, 62);

        run(0, 4, 1'b0);
        expect_int("busy_bad", busy_cnt, 0);
        expect_int("err_bad", int'(err), 1);

        run(2, 2, 1'b0);
        expect_int("writes_2x2", zwe_cnt, 3);
        expect_int("err_cleared", int'(err), 0);

        run(3, 3, 1'b1);
        expect_int("busy_3x3_noise", busy_cnt, 24);

        for (int i = 0; i < 40; i++) begin
            int sx, sy;
            sx = ($urandom % 10 == 0) ? (($urandom % 2 == 0) ? 0 : 33 + int'($urandom % 31))
                                      : 1 + int'($urandom % 12);
            sy = ($urandom % 10 == 0) ? (($urandom % 2 == 0) ? 0 : 33 + int'($urandom % 31))
                                      : 1 + int'($urandom % 12);
            run(sx, sy, bit'($urandom % 2));
        end

`ifdef CONV_ABORT_EN
        begin
            rec_t r;
            launch(3, 3);
            repeat (4) step();
            abort = 1'b1;
            expq.delete();
            r = '0; r.done = 1'b1; expq.push_back(r);
            step();
            abort = 1'b0;
            expect_int("aborted_set", int'(aborted), 1);
            expect_int("writes_abort", zwe_cnt, 1);
            step();
            run(2, 2, 1'b0);
            expect_int("aborted_cleared", int'(aborted), 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
